// File: rtl/rect_filler_pkg.sv
// rect_filler_pkg: shared definitions for the rectangle filler and its helpers.
//   - fill_state_t : FSM encoding (IDLE, FILL)
//   - PIX_W        : bits per pixel word in the frame buffer
//   - DEF_PPW      : pixels per write-data word for the default 128-bit bus
//   - DEF_MASK_W   : byte-mask width for the default 128-bit bus
//   - PIX_PAD      : pad byte placed above the 24-bit colour
//   - pixel_word() : builds one 32-bit frame-buffer pixel from a colour
package rect_filler_pkg;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } fill_state_t;

    localparam int unsigned PIX_W      = 32;
    localparam int unsigned DEF_PPW    = 128 / PIX_W;
    localparam int unsigned DEF_MASK_W = 128 / 8;
    localparam logic [7:0]  PIX_PAD    = 8'd0;

    function automatic logic [PIX_W-1:0] pixel_word(input logic [23:0] color);
        return {PIX_PAD, color};
    endfunction

endpackage

// File: rtl/rect_filler_if.sv
// rect_filler_if: command and DDR2-FIFO signal bundle of the rectangle filler.
//   master : command source and FIFO side (drives valid/coords/color/base and
//            the FIFO full flags, observes pushes, ready and done)
//   slave  : the filler itself
// Signals: valid, x0, y0, x1, y1, color, frame_base, af_full, wdf_full,
//          af_addr_din, af_wr_en, wdf_din, wdf_mask_din, wdf_wr_en, ready, done.
interface rect_filler_if #(
    parameter int unsigned COORD_W = 10,
    parameter int unsigned ADDR_W  = 31,
    parameter int unsigned DATA_W  = 128
);
    logic                  valid;
    logic [COORD_W-1:0]    x0;
    logic [COORD_W-1:0]    y0;
    logic [COORD_W-1:0]    x1;
    logic [COORD_W-1:0]    y1;
    logic [23:0]           color;
    logic [31:0]           frame_base;
    logic                  af_full;
    logic                  wdf_full;
    logic [ADDR_W-1:0]     af_addr_din;
    logic                  af_wr_en;
    logic [DATA_W-1:0]     wdf_din;
    logic [DATA_W/8-1:0]   wdf_mask_din;
    logic                  wdf_wr_en;
    logic                  ready;
    logic                  done;

    modport master (
        output valid, x0, y0, x1, y1, color, frame_base, af_full, wdf_full,
        input  af_addr_din, af_wr_en, wdf_din, wdf_mask_din, wdf_wr_en, ready, done
    );

    modport slave (
        input  valid, x0, y0, x1, y1, color, frame_base, af_full, wdf_full,
        output af_addr_din, af_wr_en, wdf_din, wdf_mask_din, wdf_wr_en, ready, done
    );
endinterface

// File: rtl/rect_mask_gen.sv
// rect_mask_gen: byte mask for one write-data word of a horizontal span.
//   wx_i   : word index within the row (pixel x = wx_i*PPW + p)
//   x0_i   : first pixel of the span (inclusive)
//   x1_i   : last pixel of the span (inclusive)
//   mask_o : 1 = byte not written; pixel p owns bytes 4p..4p+3
// Purely combinational so the line engine can reuse it.
module rect_mask_gen #(
    parameter int unsigned PPW     = 4,
    parameter int unsigned COORD_W = 10
) (
    input  logic [COORD_W-1:0] wx_i,
    input  logic [COORD_W-1:0] x0_i,
    input  logic [COORD_W-1:0] x1_i,
    output logic [PPW*4-1:0]   mask_o
);
    localparam int unsigned PPW_LOG2 = $clog2(PPW);

    // One extra bit so wx*PPW+p cannot wrap past the coordinate range.
    always_comb begin
        mask_o = '1;
        for (int p = 0; p < PPW; p++) begin
            logic [COORD_W:0] px;
            px = ((COORD_W+1)'(wx_i) << PPW_LOG2) + (COORD_W+1)'(p);
            if ((px >= {1'b0, x0_i}) && (px <= {1'b0, x1_i})) begin
                mask_o[4*p +: 4] = 4'h0;
            end else begin
                mask_o[4*p +: 4] = 4'hF;
            end
        end
    end
endmodule

// File: rtl/rect_filler.sv
// rect_filler: fills an axis-aligned rectangle (inclusive corners) of a DDR2
// frame buffer with a solid colour, one masked 128-bit word per cycle.
//   clk, rst      : system clock, synchronous active-high reset
//   bus (slave)   : command handshake (valid/ready/done, corners, colour,
//                   frame base) and paired address/write-data FIFO pushes
// Optional build macro RECT_FILLER_STATS_EN adds:
//   stall_cycles  : FILL cycles without a push since the last accept
//   words_written : pushes since the last accept
module rect_filler
    import rect_filler_pkg::*;
#(
    parameter int unsigned FRAME_W         = 800,
    parameter int unsigned FRAME_H         = 600,
    parameter int unsigned ROW_STRIDE_LOG2 = 10,
    parameter int unsigned DATA_W          = 128,
    parameter int unsigned ADDR_W          = 31,
    parameter int unsigned COORD_W         = 10
) (
    input  logic         clk,
    input  logic         rst,
    rect_filler_if.slave bus
`ifdef RECT_FILLER_STATS_EN
    ,
    output logic [31:0]  stall_cycles,
    output logic [31:0]  words_written
`endif
);
    localparam int unsigned PPW      = DATA_W / PIX_W;
    localparam int unsigned PPW_LOG2 = $clog2(PPW);
    localparam logic [COORD_W-1:0] MAX_X = COORD_W'(FRAME_W - 1);
    localparam logic [COORD_W-1:0] MAX_Y = COORD_W'(FRAME_H - 1);

    fill_state_t         state_q;
    logic                done_q;
    logic [COORD_W-1:0]  x0_q, x1_q, y1_q;
    logic [COORD_W-1:0]  wx_q, wx_first_q, wx_last_q, y_q;
    logic [23:0]         color_q;
    logic [ADDR_W-1:0]   base_q;

    logic [COORD_W-1:0]  cx0_s, cy0_s, cx1_s, cy1_s;
    logic                empty_s, accept_s, push_s;
    logic [ADDR_W-1:0]   addr_s;
    logic [DATA_W/8-1:0] gen_mask_s;

    assign cx0_s    = (bus.x0 > MAX_X) ? MAX_X : bus.x0;
    assign cx1_s    = (bus.x1 > MAX_X) ? MAX_X : bus.x1;
    assign cy0_s    = (bus.y0 > MAX_Y) ? MAX_Y : bus.y0;
    assign cy1_s    = (bus.y1 > MAX_Y) ? MAX_Y : bus.y1;
    assign empty_s  = (cx0_s > cx1_s) || (cy0_s > cy1_s);
    assign accept_s = (state_q == S_IDLE) && bus.valid;

    // rst gates the push directly so an abort stops writes in the same cycle.
    assign push_s = (state_q == S_FILL) && !bus.af_full && !bus.wdf_full && !rst;

    assign addr_s = base_q + (ADDR_W'(y_q) << ROW_STRIDE_LOG2) + (ADDR_W'(wx_q) << PPW_LOG2);

    rect_mask_gen #(
        .PPW     (PPW),
        .COORD_W (COORD_W)
    ) u_mask (
        .wx_i   (wx_q),
        .x0_i   (x0_q),
        .x1_i   (x1_q),
        .mask_o (gen_mask_s)
    );

    assign bus.af_wr_en     = push_s;
    assign bus.wdf_wr_en    = push_s;
    assign bus.af_addr_din  = addr_s;
    assign bus.wdf_din      = {PPW{pixel_word(color_q)}};
    assign bus.wdf_mask_din = ((state_q == S_FILL) && !rst) ? gen_mask_s : '1;
    assign bus.ready        = (state_q == S_IDLE) && !rst;
    assign bus.done         = done_q && !rst;

    // Command FSM: accept/clamp in IDLE, raster-walk words in FILL.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            done_q     <= 1'b0;
            x0_q       <= '0;
            x1_q       <= '0;
            y1_q       <= '0;
            wx_q       <= '0;
            wx_first_q <= '0;
            wx_last_q  <= '0;
            y_q        <= '0;
            color_q    <= 24'd0;
            base_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.valid) begin
                        x0_q       <= cx0_s;
                        x1_q       <= cx1_s;
                        y1_q       <= cy1_s;
                        wx_q       <= cx0_s >> PPW_LOG2;
                        wx_first_q <= cx0_s >> PPW_LOG2;
                        wx_last_q  <= cx1_s >> PPW_LOG2;
                        y_q        <= cy0_s;
                        color_q    <= bus.color;
                        base_q     <= ADDR_W'(bus.frame_base);
                        if (empty_s) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (push_s) begin
                        if (wx_q == wx_last_q) begin
                            if (y_q == y1_q) begin
                                state_q <= S_IDLE;
                                done_q  <= 1'b1;
                            end else begin
                                wx_q <= wx_first_q;
                                y_q  <= y_q + COORD_W'(1);
                            end
                        end else begin
                            wx_q <= wx_q + COORD_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef RECT_FILLER_STATS_EN
    // Per-command counters, cleared on accept, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles  <= 32'd0;
            words_written <= 32'd0;
        end else if (accept_s) begin
            stall_cycles  <= 32'd0;
            words_written <= 32'd0;
        end else if (state_q == S_FILL) begin
            if (push_s) begin
                if (words_written != 32'hFFFF_FFFF) begin
                    words_written <= words_written + 32'd1;
                end
            end else begin
                if (stall_cycles != 32'hFFFF_FFFF) begin
                    stall_cycles <= stall_cycles + 32'd1;
                end
            end
        end
    end
`else
    logic unused_accept_s;
    assign unused_accept_s = accept_s;
`endif

endmodule

// File: tb/tb_rect_filler.sv
// tb_rect_filler: self-checking bench for rect_filler. A reference model
// enumerates the expected (address, mask) words of every command row by row;
// each observed push is compared in order against that list.
module tb_rect_filler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    rect_filler_if #(.COORD_W(10), .ADDR_W(31), .DATA_W(128)) bus ();

`ifdef RECT_FILLER_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] words_written;
`endif

    rect_filler dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus.slave)
`ifdef RECT_FILLER_STATS_EN
        ,
        .stall_cycles  (stall_cycles),
        .words_written (words_written)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one command. mode 0: no backpressure, 1: random, 2: scripted
    // (af_full cycles 3..7, wdf_full cycles 8..10). abort_after>0 returns
    // right after that many pushes have been seen, leaving the fill running.
    task automatic run_cmd(input int ax0, input int ay0, input int ax1, input int ay1,
                           input logic [23:0] col, input logic [31:0] base,
                           input int mode, input int abort_after);
        int cx0, cy0, cx1, cy1, n, got, cyc, stalls, budget;
        bit seen_done;
        logic [31:0] a;
        logic [15:0] m;
        logic [30:0] eaddr[$];
        logic [15:0] emask[$];

        cx0 = (ax0 > 799) ? 799 : ax0;
        cx1 = (ax1 > 799) ? 799 : ax1;
        cy0 = (ay0 > 599) ? 599 : ay0;
        cy1 = (ay1 > 599) ? 599 : ay1;
        if (cx0 <= cx1 && cy0 <= cy1) begin
            for (int y = cy0; y <= cy1; y++) begin
                for (int w = cx0 / 4; w <= cx1 / 4; w++) begin
                    a = base + 32'(y * 1024) + 32'(w * 4);
                    eaddr.push_back(a[30:0]);
                    m = 16'hFFFF;
                    for (int p = 0; p < 4; p++) begin
                        if (w * 4 + p >= cx0 && w * 4 + p <= cx1) m[4*p +: 4] = 4'h0;
                    end
                    emask.push_back(m);
                end
            end
        end
        n = eaddr.size();
        budget = 10 * n + 60;

        @(negedge clk);
        chk("ready_idle", 128'(bus.ready), 128'(1'b1));
        bus.valid      = 1'b1;
        bus.x0         = ax0[9:0];
        bus.y0         = ay0[9:0];
        bus.x1         = ax1[9:0];
        bus.y1         = ay1[9:0];
        bus.color      = col;
        bus.frame_base = base;
        bus.af_full    = 1'b0;
        bus.wdf_full   = 1'b0;
        #1;
        chk("no_push_on_accept", 128'(bus.af_wr_en), 128'(1'b0));
        @(negedge clk);
        bus.valid      = 1'b0;
        bus.x0         = 10'($urandom);
        bus.y0         = 10'($urandom);
        bus.x1         = 10'($urandom);
        bus.y1         = 10'($urandom);
        bus.color      = 24'($urandom);
        bus.frame_base = $urandom;

        cyc = 0; got = 0; stalls = 0; seen_done = 1'b0;
        while (!seen_done && cyc < budget) begin
            case (mode)
                1: begin
                    bus.af_full  = ($urandom_range(0, 3) == 0);
                    bus.wdf_full = ($urandom_range(0, 4) == 0);
                end
                2: begin
                    bus.af_full  = (cyc >= 3 && cyc <= 7);
                    bus.wdf_full = (cyc >= 8 && cyc <= 10);
                end
                default: begin
                    bus.af_full  = 1'b0;
                    bus.wdf_full = 1'b0;
                end
            endcase
            #1;
            if (bus.done) begin
                seen_done = 1'b1;
                chk("push_count", 128'(got), 128'(n));
                chk("ready_with_done", 128'(bus.ready), 128'(1'b1));
                chk("no_push_with_done", 128'(bus.af_wr_en), 128'(1'b0));
                if (n == 0) chk("empty_done_latency", 128'(cyc), 128'(0));
            end else begin
                chk("wr_en_pair", 128'(bus.wdf_wr_en), 128'(bus.af_wr_en));
                chk("ready_busy", 128'(bus.ready), 128'(1'b0));
                if (bus.af_full || bus.wdf_full) chk("stall_no_push", 128'(bus.af_wr_en), 128'(1'b0));
                if (bus.af_wr_en) begin
                    if (got < n) begin
                        chk("addr", 128'(bus.af_addr_din), 128'(eaddr[got]));
                        chk("mask", 128'(bus.wdf_mask_din), 128'(emask[got]));
                        chk("data", bus.wdf_din, {4{8'd0, col}});
                    end else begin
                        chk("extra_push", 128'(got), 128'(n));
                    end
                    got++;
                    if (abort_after > 0 && got == abort_after) return;
                end else begin
                    stalls++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        if (!seen_done) chk("done_timeout", 128'(cyc), 128'(budget + 1));
        bus.af_full  = 1'b0;
        bus.wdf_full = 1'b0;
        #1;
        chk("done_single_cycle", 128'(bus.done), 128'(1'b0));
`ifdef RECT_FILLER_STATS_EN
        chk("stat_stalls", 128'(stall_cycles), 128'(stalls));
        chk("stat_words", 128'(words_written), 128'(n));
`endif
        if (mode == 2) chk("scripted_stalls", 128'(stalls), 128'(8));
    endtask

    initial begin
        int rx0, rx1, ry0, ry1, t;
        bus.valid = 1'b0; bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;
        bus.color = 24'd0; bus.frame_base = 32'd0;
        bus.af_full = 1'b0; bus.wdf_full = 1'b0;

        // Reset state
        @(negedge clk); @(negedge clk);
        #1;
        chk("rst_ready", 128'(bus.ready), 128'(1'b0));
        chk("rst_done", 128'(bus.done), 128'(1'b0));
        chk("rst_af_wr_en", 128'(bus.af_wr_en), 128'(1'b0));
        chk("rst_wdf_wr_en", 128'(bus.wdf_wr_en), 128'(1'b0));
        chk("rst_mask", 128'(bus.wdf_mask_din), 128'(16'hFFFF));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 128'(bus.ready), 128'(1'b1));

        // Directed cases
        run_cmd(5, 3, 5, 3, 24'hA1B2C3, 32'd0, 0, 0);
        run_cmd(2, 10, 9, 11, 24'h123456, 32'd0, 0, 0);
        run_cmd(2, 10, 9, 11, 24'h00FF00, 32'h0000_4000, 2, 0);
        run_cmd(10, 0, 4, 5, 24'h777777, 32'd0, 0, 0);
        run_cmd(3, 9, 7, 2, 24'h777777, 32'd0, 0, 0);
        run_cmd(796, 598, 900, 700, 24'hFEDCBA, 32'h0001_0000, 0, 0);
        run_cmd(0, 0, 799, 19, 24'h0F0F0F, 32'h0010_0000, 0, 0);
        run_cmd(0, 580, 799, 599, 24'h0F0F0F, 32'h8000_0000, 1, 0);

        // Randomized rectangles with random backpressure
        for (int i = 0; i < 12; i++) begin
            rx0 = $urandom_range(0, 1023);
            rx1 = $urandom_range(0, 1023);
            if ((i % 4) != 0 && rx0 > rx1) begin
                t = rx0; rx0 = rx1; rx1 = t;
            end
            ry0 = $urandom_range(0, 620);
            ry1 = ry0 + $urandom_range(0, 2);
            run_cmd(rx0, ry0, rx1, ry1, 24'($urandom), $urandom, 1, 0);
        end

        // Reset during a full-frame fill, then a fresh command
        run_cmd(0, 0, 799, 599, 24'h55AA55, 32'h0010_0000, 0, 7);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_no_push", 128'(bus.af_wr_en), 128'(1'b0));
        chk("abort_ready", 128'(bus.ready), 128'(1'b0));
        chk("abort_mask", 128'(bus.wdf_mask_din), 128'(16'hFFFF));
        @(negedge clk);
        #1;
        chk("abort_no_done", 128'(bus.done), 128'(1'b0));
        chk("abort_still_quiet", 128'(bus.af_wr_en), 128'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_abort", 128'(bus.ready), 128'(1'b1));
        chk("no_done_after_abort", 128'(bus.done), 128'(1'b0));
        chk("no_push_after_abort", 128'(bus.af_wr_en), 128'(1'b0));
        run_cmd(40, 100, 47, 100, 24'h010203, 32'h0000_0200, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
